// File: rtl/obj_pkg.sv
// Shared constants for the obstacle sensor front end: sensor indices,
// frontend FSM state encodings and default timing values.
package obj_pkg;

  localparam int SEN_L   = 0;
  localparam int SEN_R   = 1;
  localparam int SEN_F   = 2;
  localparam int NUM_SEN = 3;

  localparam int DEF_TRIG_CYCLES    = 1000;
  localparam int DEF_THRESH_CYCLES  = 58000;
  localparam int DEF_TIMEOUT_CYCLES = 2500000;
  localparam int DEF_GAP_CYCLES     = 100000;
  localparam int DEF_HITS           = 3;
  localparam int DEF_CNT_W          = 22;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  typedef logic [1:0] sen_sel_t;

  // Round-robin successor: left -> right -> front -> left.
  function automatic sen_sel_t next_sel(input sen_sel_t s);
    return (s >= sen_sel_t'(NUM_SEN - 1)) ? sen_sel_t'(0) : s + sen_sel_t'(1);
  endfunction

endpackage

// File: rtl/obj_sensor_frontend_if.sv
// Sensor-side and result-side signals of the front end.
// master = the front end itself, slave = sensors / obj_fsm / debug.
interface obj_sensor_frontend_if #(
  parameter int CNT_W = 22
);
  import obj_pkg::*;

  logic [NUM_SEN-1:0] echo;
  logic [NUM_SEN-1:0] trig;
  logic               L;
  logic               R;
  logic               F;
  logic               dist_valid;
  sen_sel_t           dist_sel;
  logic [CNT_W-1:0]   dist_cycles;

  modport master (
    input  echo,
    output trig, L, R, F, dist_valid, dist_sel, dist_cycles
  );

  modport slave (
    output echo,
    input  trig, L, R, F, dist_valid, dist_sel, dist_cycles
  );

endinterface

// File: rtl/obj_hit_filter.sv
// Per-sensor debounce: the flag only flips after HITS consecutive
// decisions that disagree with it.
module obj_hit_filter #(
  parameter int HITS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic upd,
  input  logic hit,
  output logic flag
);

  localparam logic [3:0] RUN_LAST = 4'(HITS - 1);

  logic [3:0] run;

  // Count disagreeing decisions; any agreeing decision restarts the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= 1'b0;
      run  <= '0;
    end else if (upd) begin
      if (hit != flag) begin
        if (run == RUN_LAST) begin
          flag <= ~flag;
          run  <= '0;
        end else begin
          run <= run + 4'd1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/obj_sensor_frontend.sv
// Round-robin ultrasonic ranging front end: trigger, time the echo,
// threshold it and debounce the per-sensor hit decision into L/R/F.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | one-cycle pause before triggering sensor sel
// TRIG      | trig[sel] high, TRIG_CYCLES long (down-counter)
// WAIT_RISE | waiting for a synchronised echo rising edge, or timeout
// MEASURE   | counting echo-high cycles, saturating at TIMEOUT
// DONE      | publish result, update the filter of sensor sel
// GAP       | GAP_CYCLES idle (down-counter), then advance sel
module obj_sensor_frontend
  import obj_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int THRESH_CYCLES  = DEF_THRESH_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int HITS           = DEF_HITS,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                   clk,
  input logic                   reset,
  obj_sensor_frontend_if.master bus
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] THR       = CNT_W'(THRESH_CYCLES);
  localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  logic [NUM_SEN-1:0] echo_s1;
  logic [NUM_SEN-1:0] echo_s2;
  logic [NUM_SEN-1:0] echo_d;
  logic [2:0]         state;
  sen_sel_t           sel;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   tmr;
  logic [CNT_W-1:0]   width;
  logic               tout;
  logic [NUM_SEN-1:0] trig_q;
  logic               dist_valid_q;
  sen_sel_t           dist_sel_q;
  logic [CNT_W-1:0]   dist_cycles_q;
  logic [NUM_SEN-1:0] flag;
  logic               e_cur;
  logic               rise;
  logic               hit_dec;

  assign e_cur   = echo_s2[sel];
  assign rise    = echo_s2[sel] & ~echo_d[sel];
  assign hit_dec = (width < THR) && !tout;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_s1 <= '0;
      echo_s2 <= '0;
      echo_d  <= '0;
    end else begin
      echo_s1 <= bus.echo;
      echo_s2 <= echo_s1;
      echo_d  <= echo_s2;
    end
  end

  // Measurement sequencer; trigger and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel           <= '0;
      cnt           <= '0;
      tmr           <= '0;
      width         <= '0;
      tout          <= 1'b0;
      trig_q        <= '0;
      dist_valid_q  <= 1'b0;
      dist_sel_q    <= '0;
      dist_cycles_q <= '0;
    end else begin
      dist_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          trig_q <= NUM_SEN'(1) << sel;
          tmr    <= TRIG_LOAD;
          state  <= ST_TRIG;
        end
        ST_TRIG: begin
          if (tmr == '0) begin
            trig_q <= '0;
            cnt    <= '0;
            tout   <= 1'b0;
            state  <= ST_WAIT_RISE;
          end else begin
            tmr <= tmr - ONE;
          end
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            cnt   <= ONE;
            state <= ST_MEASURE;
          end else if (cnt == TMO) begin
            width <= TMO;
            tout  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_MEASURE: begin
          if (!e_cur) begin
            width <= cnt;
            tout  <= 1'b0;
            state <= ST_DONE;
          end else if (cnt == TMO) begin
            width <= TMO;
            tout  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_DONE: begin
          dist_valid_q  <= 1'b1;
          dist_sel_q    <= sel;
          dist_cycles_q <= width;
          tmr           <= GAP_LOAD;
          state         <= ST_GAP;
        end
        ST_GAP: begin
          if (tmr == '0) begin
            sel   <= next_sel(sel);
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - ONE;
          end
        end
        default: begin
          trig_q <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SEN; i++) begin : g_filt
    obj_hit_filter #(.HITS(HITS)) u_filt (
      .clk   (clk),
      .reset (reset),
      .upd   ((state == ST_DONE) && (sel == sen_sel_t'(i))),
      .hit   (hit_dec),
      .flag  (flag[i])
    );
  end

  assign bus.trig        = trig_q;
  assign bus.L           = flag[SEN_L];
  assign bus.R           = flag[SEN_R];
  assign bus.F           = flag[SEN_F];
  assign bus.dist_valid  = dist_valid_q;
  assign bus.dist_sel    = dist_sel_q;
  assign bus.dist_cycles = dist_cycles_q;

endmodule

// File: doc/obj_sensor_frontend.md
Name: obj_sensor_frontend

Overview:
- Upstream stage of obj_fsm.
- Drives three ultrasonic range sensors (left, right, front) one at a time in round-robin order.
- For each sensor it sends a trigger pulse, times the echo pulse, compares the width against a distance threshold, and filters the hit/miss decisions.
- Produces the level flags L, R, F that obj_fsm consumes, plus the raw width for debug.

Parameters:
- TRIG_CYCLES, 1000: trigger pulse width in clk cycles (10 us at 100 MHz).
- THRESH_CYCLES, 58000: a valid echo strictly shorter than this is a hit (object near).
- TIMEOUT_CYCLES, 2500000: maximum wait for an echo rise, and maximum echo width; reaching it is a miss.
- GAP_CYCLES, 100000: idle time after each measurement before moving to the next sensor.
- HITS, 3: number of consecutive equal decisions needed to change a flag; 1..15.
- CNT_W, 22: width of the counters and of dist_cycles; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- echo  in  3  raw echo inputs, asynchronous; [0]=left, [1]=right, [2]=front.
- trig  out  3  sensor trigger outputs, same bit order as echo; at most one bit high at a time.
- L  out  1  left object flag (filtered level) to obj_fsm.
- R  out  1  right object flag to obj_fsm.
- F  out  1  front object flag to obj_fsm.
- dist_valid  out  1  one-cycle pulse when a measurement completes.
- dist_sel  out  2  sensor index of the last measurement (0/1/2).
- dist_cycles  out  CNT_W  echo width of the last measurement; equals TIMEOUT_CYCLES on a miss by timeout.

Behaviour:
- Echo synchronisation: each echo bit passes through a 2-flop synchroniser.
  - All echo timing below uses the synchronised value, so echo edges are seen 2 cycles late.
  - Only the currently selected sensor's echo is examined; the other two are ignored.
- Reset (synchronous): state=IDLE, sel=0, trig=0, L=R=F=0, filter run counters=0, dist_valid=0, dist_sel=0, dist_cycles=0.
- IDLE: lasts 1 cycle, then go to TRIG.
- TRIG: trig[sel]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with the counter cleared.
- WAIT_RISE:
  - A rising edge is a synchronised echo that was 0 last cycle and is 1 this cycle. A stuck-high echo therefore never starts a measurement.
  - On a rising edge: go to MEASURE with count=1.
  - If the counter reaches TIMEOUT_CYCLES first: record a miss with width=TIMEOUT_CYCLES and go to DONE.
- MEASURE:
  - Count increments each cycle while echo=1.
  - On echo=0: width=count, then go to DONE.
  - If count reaches TIMEOUT_CYCLES: saturate, width=TIMEOUT_CYCLES (miss), go to DONE.
- DONE (1 cycle):
  - dist_valid=1, dist_sel=sel, dist_cycles=width.
  - hit = (width < THRESH_CYCLES) and not timed out.
  - Filter update for sensor sel is registered this cycle, so flags change on the same cycle as dist_valid.
  - Go to GAP.
- GAP: wait GAP_CYCLES, then advance sel 0→1→2→0 (wrap at 2) and go to IDLE.
- Hit filter (one per sensor, state = flag + run counter):
  - If decision != flag: run++; when run reaches HITS, flag toggles and run=0.
  - If decision == flag: run=0.
  - A flag changes only after exactly HITS consecutive opposite decisions for that sensor; other sensors' measurements do not affect it.
- Full round-robin period per sensor ≈ 3 × (1 + TRIG_CYCLES + wait + width + 1 + GAP_CYCLES).
- Reset mid-operation:
  - Abort immediately; trig goes low on the next edge.
  - All flags clear; measurement restarts at sel=0.
- State encoding: IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP. Unused encodings return to IDLE.

Decomposition:
- Shared package obj_pkg:
  - sensor index constants SEN_L=0, SEN_R=1, SEN_F=2, NUM_SEN=3;
  - state enum/localparams for the frontend FSM;
  - default THRESH/TIMEOUT values.
- Sub-module obj_hit_filter: inputs clk, reset, upd, hit; output flag; parameter HITS. Instantiated 3 times, with upd = DONE && sel==index.

Test Plan (bench params: TRIG_CYCLES=4, THRESH_CYCLES=50, TIMEOUT_CYCLES=200, GAP_CYCLES=10, HITS=2, CNT_W=8):
- Reset release, all echoes 0 → trig[0] high for exactly 4 cycles; after 200 wait cycles dist_valid with dist_sel=0, dist_cycles=200; next trigger is trig[1]; L=R=F stay 0.
- Left echo 30 cycles wide on two consecutive left turns → dist_cycles=30 both times; L rises on the second DONE, not the first; R and F stay 0.
- Front echo 50 cycles wide (equal to threshold) → no hit; F stays 0. Front echo 49 cycles twice → F=1.
- With L=1, left echo held high for more than 200 cycles → dist_cycles=200 (miss); after a second miss L=0.
- Echo[2] stuck high from reset → the front slot times out (no rising edge seen); left and right measurements are unaffected; sel wraps 2→0.
- reset asserted during the MEASURE phase with L=1 → next cycle trig=0, L=0, dist_valid=0; the following trigger is trig[0].
